// File: rtl/bus_arbiter.sv
// Single-outstanding arbiter between the fetch read port and the execute data port onto
// one external memory bus. Data wins by default; a streak counter hands fetch one grant.
module bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_read_valid,
  input  logic [31:0] fetch_read_address,
  output logic        fetch_read_ready,
  output logic [31:0] fetch_read_data,
  input  logic        fetch_flush,
  input  logic        data_valid,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_write_data,
  output logic        data_ready,
  output logic [31:0] data_read_data,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  input  logic        bus_ready,
  input  logic [31:0] bus_read_data
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          owner_fetch, owner_fetch_nx;
  logic [SW-1:0] streak, streak_nx;
  logic          discard, discard_nx;

  logic          bus_valid_nx;
  logic          bus_write_nx;
  logic [AW-1:0] bus_address_nx;
  logic [DW-1:0] bus_write_data_nx;
  logic          fetch_read_ready_nx;
  logic [DW-1:0] fetch_read_data_nx;
  logic          data_ready_nx;
  logic [DW-1:0] data_read_data_nx;

  logic          fetch_req;
  logic          grant_data;
  logic          grant_fetch;

  // A flush in the arbitration cycle hides the fetch request for that cycle only.
  assign fetch_req   = fetch_read_valid && !fetch_flush;
  assign grant_data  = data_valid && !(fetch_req && (streak == SW'(STARVE_LIMIT)));
  assign grant_fetch = fetch_req && !grant_data;

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      owner_fetch      <= 1'b0;
      streak           <= '0;
      discard          <= 1'b0;
      bus_valid        <= 1'b0;
      bus_write        <= 1'b0;
      bus_address      <= '0;
      bus_write_data   <= '0;
      fetch_read_ready <= 1'b0;
      fetch_read_data  <= '0;
      data_ready       <= 1'b0;
      data_read_data   <= '0;
    end else begin
      state            <= state_nx;
      owner_fetch      <= owner_fetch_nx;
      streak           <= streak_nx;
      discard          <= discard_nx;
      bus_valid        <= bus_valid_nx;
      bus_write        <= bus_write_nx;
      bus_address      <= bus_address_nx;
      bus_write_data   <= bus_write_data_nx;
      fetch_read_ready <= fetch_read_ready_nx;
      fetch_read_data  <= fetch_read_data_nx;
      data_ready       <= data_ready_nx;
      data_read_data   <= data_read_data_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx            = state;
    owner_fetch_nx      = owner_fetch;
    streak_nx           = streak;
    discard_nx          = discard;
    bus_valid_nx        = bus_valid;
    bus_write_nx        = bus_write;
    bus_address_nx      = bus_address;
    bus_write_data_nx   = bus_write_data;
    fetch_read_ready_nx = 1'b0;
    fetch_read_data_nx  = fetch_read_data;
    data_ready_nx       = 1'b0;
    data_read_data_nx   = data_read_data;

    case (state)
      IDLE: begin
        if (!fetch_req) begin
          streak_nx = '0;
        end
        if (grant_data) begin
          owner_fetch_nx    = 1'b0;
          bus_valid_nx      = 1'b1;
          bus_write_nx      = data_write;
          bus_address_nx    = data_address;
          bus_write_data_nx = data_write_data;
          state_nx          = ISSUE;
          // Count data grants that overtook a waiting fetch.
          if (fetch_req && (streak != SW'(STARVE_LIMIT))) begin
            streak_nx = streak + SW'(1);
          end
        end else if (grant_fetch) begin
          owner_fetch_nx    = 1'b1;
          bus_valid_nx      = 1'b1;
          bus_write_nx      = 1'b0;
          bus_address_nx    = fetch_read_address;
          bus_write_data_nx = '0;
          streak_nx         = '0;
          state_nx          = ISSUE;
        end
      end

      ISSUE: begin
        if (owner_fetch && fetch_flush) begin
          discard_nx = 1'b1;
        end
        if (bus_ready) begin
          bus_valid_nx = 1'b0;
          state_nx     = RESPOND;
          if (owner_fetch) begin
            // A redirected fetch still completes on the bus but is dropped here.
            if (!(discard || fetch_flush)) begin
              fetch_read_ready_nx = 1'b1;
              fetch_read_data_nx  = bus_read_data;
            end
          end else begin
            data_ready_nx = 1'b1;
            if (!bus_write) begin
              data_read_data_nx = bus_read_data;
            end
          end
        end
      end

      RESPOND: begin
        discard_nx = 1'b0;
        state_nx   = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run scored against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_read_valid = 1'b0;
  logic [31:0] fetch_read_address = '0;
  logic        fetch_read_ready;
  logic [31:0] fetch_read_data;
  logic        fetch_flush = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_address = '0;
  logic [31:0] data_write_data = '0;
  logic        data_ready;
  logic [31:0] data_read_data;
  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_read_data = '0;

  always #5 clock = ~clock;

  bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock              (clock),
    .reset              (reset),
    .fetch_read_valid   (fetch_read_valid),
    .fetch_read_address (fetch_read_address),
    .fetch_read_ready   (fetch_read_ready),
    .fetch_read_data    (fetch_read_data),
    .fetch_flush        (fetch_flush),
    .data_valid         (data_valid),
    .data_write         (data_write),
    .data_address       (data_address),
    .data_write_data    (data_write_data),
    .data_ready         (data_ready),
    .data_read_data     (data_read_data),
    .bus_valid          (bus_valid),
    .bus_write          (bus_write),
    .bus_address        (bus_address),
    .bus_write_data     (bus_write_data),
    .bus_ready          (bus_ready),
    .bus_read_data      (bus_read_data)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fv;
    logic [31:0] fa;
    logic        fl;
    logic        dv;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [31:0] rd;
    logic        grant;
    logic        own_f;
    logic        ew;
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [7];

  // Last values the read-data outputs must be holding.
  logic [31:0] m_f = '0;
  logic [31:0] m_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_inputs();
    fetch_read_valid = 1'b0;
    fetch_flush      = 1'b0;
    data_valid       = 1'b0;
    data_write       = 1'b0;
    bus_ready        = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 32'({fetch_read_ready, data_ready, bus_valid, bus_write}), 32'h0);
    chk(name, bus_address, 32'h0);
    chk(name, bus_write_data, 32'h0);
    chk(name, fetch_read_data, 32'h0);
    chk(name, data_read_data, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] starve_exp;
    int g;

    vecs[0] = '{1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF,
                1'b1, 1'b1, 1'b0, 32'h1000, 32'h0};
    vecs[1] = '{1'b1, 32'h1004, 1'b0, 1'b1, 1'b1, 32'h2000, 32'h55AA, 32'h0,
                1'b1, 1'b0, 1'b1, 32'h2000, 32'h55AA};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 32'hCAFEF00D,
                1'b1, 1'b0, 1'b0, 32'h3000, 32'h0};
    vecs[3] = '{1'b1, 32'h1008, 1'b0, 1'b0, 1'b1, 32'h2004, 32'h77, 32'h11112222,
                1'b1, 1'b1, 1'b0, 32'h1008, 32'h0};
    vecs[4] = '{1'b1, 32'h100C, 1'b1, 1'b1, 1'b0, 32'h3004, 32'h0, 32'h33334444,
                1'b1, 1'b0, 1'b0, 32'h3004, 32'h0};
    vecs[5] = '{1'b1, 32'h1010, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h5A5A5A5A,
                1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF};

    // Reset state.
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;

    // Single transactions from IDLE, one per table row.
    for (int i = 0; i < 7; i++) begin
      fetch_read_valid   = vecs[i].fv;
      fetch_read_address = vecs[i].fa;
      fetch_flush        = vecs[i].fl;
      data_valid         = vecs[i].dv;
      data_write         = vecs[i].dw;
      data_address       = vecs[i].da;
      data_write_data    = vecs[i].dd;
      step();
      if (!vecs[i].grant) begin
        chk("tv_no_grant", 32'(bus_valid), 32'h0);
        clr_inputs();
        step();
        continue;
      end
      fetch_flush = 1'b0;
      chk("tv_bus_valid", 32'(bus_valid), 32'h1);
      chk("tv_bus_write", 32'(bus_write), 32'(vecs[i].ew));
      chk("tv_bus_address", bus_address, vecs[i].ea);
      chk("tv_bus_wdata", bus_write_data, vecs[i].ed);
      bus_ready     = 1'b1;
      bus_read_data = vecs[i].rd;
      step();
      if (vecs[i].own_f) m_f = vecs[i].rd;
      else if (!vecs[i].ew) m_d = vecs[i].rd;
      chk("tv_fetch_ready", 32'(fetch_read_ready), 32'(vecs[i].own_f));
      chk("tv_data_ready", 32'(data_ready), 32'(!vecs[i].own_f));
      chk("tv_bus_valid_done", 32'(bus_valid), 32'h0);
      chk("tv_fetch_rdata", fetch_read_data, m_f);
      chk("tv_data_rdata", data_read_data, m_d);
      clr_inputs();
      step();
      chk("tv_pulse_end", 32'({fetch_read_ready, data_ready}), 32'h0);
      step();
      chk("tv_idle", 32'(bus_valid), 32'h0);
    end

    // Starvation guard with both requesters held.
    starve_exp         = 10'b10_0001_0000;
    fetch_read_valid   = 1'b1;
    fetch_read_address = 32'h100;
    data_valid         = 1'b1;
    data_write         = 1'b1;
    data_address       = 32'h200;
    data_write_data    = 32'h9;
    g = 0;
    for (int c = 0; c < 200 && g < 10; c++) begin
      step();
      if (bus_valid && !bus_ready) begin
        chk("starve_order", 32'(bus_address == 32'h100), 32'(starve_exp[g]));
        if (starve_exp[g]) m_f = 32'(c);
        bus_ready     = 1'b1;
        bus_read_data = 32'(c);
        g++;
      end else begin
        bus_ready = 1'b0;
      end
    end
    chk("starve_count", 32'(g), 32'd10);
    step();
    clr_inputs();
    step();
    step();
    chk("starve_fetch_rdata", fetch_read_data, m_f);

    // Flush during ISSUE with a slow bus: response swallowed.
    fetch_read_valid   = 1'b1;
    fetch_read_address = 32'h4000;
    step();
    chk("flush_issue", 32'(bus_valid), 32'h1);
    fetch_flush = 1'b1;
    step();
    fetch_flush      = 1'b0;
    fetch_read_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("flush_hold", 32'(bus_valid), 32'h1);
      chk("flush_addr", bus_address, 32'h4000);
    end
    bus_ready     = 1'b1;
    bus_read_data = 32'hBADBAD00;
    step();
    chk("flush_no_ready", 32'({fetch_read_ready, data_ready, bus_valid}), 32'h0);
    chk("flush_rdata", fetch_read_data, m_f);
    bus_ready = 1'b0;
    step();
    step();

    // Discard must not leak into the following fetch.
    fetch_read_valid   = 1'b1;
    fetch_read_address = 32'h4004;
    step();
    bus_ready     = 1'b1;
    bus_read_data = 32'h600DF00D;
    step();
    m_f = 32'h600DF00D;
    chk("post_flush_ready", 32'(fetch_read_ready), 32'h1);
    chk("post_flush_rdata", fetch_read_data, m_f);
    clr_inputs();
    step();
    step();

    // Flush in the same cycle as bus completion.
    fetch_read_valid   = 1'b1;
    fetch_read_address = 32'h5000;
    step();
    fetch_flush   = 1'b1;
    bus_ready     = 1'b1;
    bus_read_data = 32'h12345678;
    step();
    chk("flush_same_ready", 32'(fetch_read_ready), 32'h0);
    chk("flush_same_rdata", fetch_read_data, m_f);
    clr_inputs();
    step();
    step();

    // Slow bus: request fields stay put and exactly one ready pulse.
    data_valid      = 1'b1;
    data_write      = 1'b1;
    data_address    = 32'h6000;
    data_write_data = 32'hA5A5;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("slow_valid", 32'(bus_valid), 32'h1);
      chk("slow_fields", 32'({bus_write, bus_address[30:0]}), 32'h8000_6000);
      chk("slow_wdata", bus_write_data, 32'hA5A5);
      chk("slow_no_ready", 32'(data_ready), 32'h0);
      step();
    end
    bus_ready = 1'b1;
    step();
    chk("slow_ready", 32'({fetch_read_ready, data_ready, bus_valid}), 32'h2);
    chk("slow_rdata_hold", data_read_data, m_d);
    clr_inputs();
    step();
    chk("slow_single_pulse", 32'(data_ready), 32'h0);
    step();

    // Reset while a transaction is on the bus.
    data_valid   = 1'b1;
    data_write   = 1'b0;
    data_address = 32'h7000;
    step();
    reset = 1'b1;
    step();
    chk_all_zero("reset_mid");
    reset = 1'b0;
    clr_inputs();
    bus_ready     = 1'b1;
    bus_read_data = 32'hFFFF0000;
    step();
    chk("reset_ignore_bus", 32'({fetch_read_ready, data_ready, bus_valid}), 32'h0);
    chk("reset_ignore_rdata", data_read_data, 32'h0);
    bus_ready = 1'b0;
    m_f = '0;
    m_d = '0;
    step();

    // Randomized traffic against a transaction-level model.
    begin
      logic        free, free_next, grant_exp, done_exp, inflight;
      logic        f_act, d_act, d_w, own_f, e_w;
      logic [31:0] f_a, d_a, d_wd, e_a, e_wd;
      int          streak_m, delay;
      free = 1'b1; free_next = 1'b0; grant_exp = 1'b0; done_exp = 1'b0; inflight = 1'b0;
      f_act = 1'b0; d_act = 1'b0; d_w = 1'b0; own_f = 1'b0; e_w = 1'b0;
      f_a = '0; d_a = '0; d_wd = '0; e_a = '0; e_wd = '0;
      streak_m = 0; delay = 0;
      for (int c = 0; c < 3000; c++) begin
        step();
        if (grant_exp || (inflight && !done_exp)) begin
          chk("rnd_bus_valid", 32'(bus_valid), 32'h1);
          chk("rnd_bus_write", 32'(bus_write), 32'(e_w));
          chk("rnd_bus_address", bus_address, e_a);
          chk("rnd_bus_wdata", bus_write_data, e_wd);
          chk("rnd_no_ready", 32'({fetch_read_ready, data_ready}), 32'h0);
        end else if (done_exp) begin
          chk("rnd_bus_released", 32'(bus_valid), 32'h0);
          chk("rnd_ready", 32'({fetch_read_ready, data_ready}), own_f ? 32'h2 : 32'h1);
        end else begin
          chk("rnd_idle", 32'({fetch_read_ready, data_ready, bus_valid}), 32'h0);
        end
        chk("rnd_fetch_rdata", fetch_read_data, m_f);
        chk("rnd_data_rdata", data_read_data, m_d);

        if (grant_exp) begin
          inflight = 1'b1;
          delay    = int'($urandom_range(0, 3));
        end
        if (done_exp) begin
          inflight  = 1'b0;
          free_next = 1'b1;
          if (own_f) f_act = 1'b0;
          else d_act = 1'b0;
        end else if (free_next) begin
          free      = 1'b1;
          free_next = 1'b0;
        end
        grant_exp = 1'b0;
        done_exp  = 1'b0;

        if (!f_act && $urandom_range(0, 2) == 0) begin
          f_act = 1'b1;
          f_a   = $urandom & ~32'h3;
        end
        if (!d_act && $urandom_range(0, 2) == 0) begin
          d_act = 1'b1;
          d_w   = 1'($urandom_range(0, 1));
          d_a   = $urandom;
          d_wd  = $urandom;
        end
        fetch_read_valid   = f_act;
        fetch_read_address = f_a;
        fetch_flush        = 1'b0;
        data_valid         = d_act;
        data_write         = d_w;
        data_address       = d_a;
        data_write_data    = d_wd;

        bus_ready = 1'b0;
        if (inflight) begin
          if (delay == 0) begin
            bus_ready     = 1'b1;
            bus_read_data = $urandom;
            done_exp      = 1'b1;
            if (own_f) m_f = bus_read_data;
            else if (!e_w) m_d = bus_read_data;
          end else begin
            delay--;
          end
        end

        if (free) begin
          if (d_act && !(f_act && streak_m == LIMIT)) begin
            own_f = 1'b0; e_w = d_w; e_a = d_a; e_wd = d_wd;
            grant_exp = 1'b1;
            free      = 1'b0;
            streak_m  = f_act ? ((streak_m < LIMIT) ? streak_m + 1 : LIMIT) : 0;
          end else if (f_act) begin
            own_f = 1'b1; e_w = 1'b0; e_a = f_a; e_wd = '0;
            grant_exp = 1'b1;
            free      = 1'b0;
            streak_m  = 0;
          end else begin
            streak_m = 0;
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
